// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: control-bundle layout, the bubble pattern and the
// stall FSM state encoding.
package pipeline_pkg;

    localparam int CTRL_W = 18;

    // Bundle packing: {ALUOp[4:0], RegWrite, ALUSrc, RegDst, MemToReg, Jump, JumpReg,
    //                  RegDst2, MemToReg2, Rdata1ShiftMux, MemWrite[1:0], MemRead[1:0]}
    localparam int ALUOP_MSB       = 17;
    localparam int ALUOP_LSB       = 13;
    localparam int REGWRITE_BIT    = 12;
    localparam int ALUSRC_BIT      = 11;
    localparam int REGDST_BIT      = 10;
    localparam int MEMTOREG_BIT    = 9;
    localparam int JUMP_BIT        = 8;
    localparam int JUMPREG_BIT     = 7;
    localparam int REGDST2_BIT     = 6;
    localparam int MEMTOREG2_BIT   = 5;
    localparam int RDATA1SHIFT_BIT = 4;
    localparam int MEMWRITE_MSB    = 3;
    localparam int MEMWRITE_LSB    = 2;
    localparam int MEMREAD_MSB     = 1;
    localparam int MEMREAD_LSB     = 0;

    localparam logic [CTRL_W-1:0] NOP_CTRL = 18'h20000;

    localparam logic ST_IDLE    = 1'b0;
    localparam logic ST_MC_BUSY = 1'b1;

    typedef enum logic {
        IDLE    = ST_IDLE,
        MC_BUSY = ST_MC_BUSY
    } mc_state_e;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping; cleared by async reset.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (en && (count != {W{1'b1}})) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/hazard_bubble_unit.sv
// ID-stage stall/flush controller: load-use and multi-cycle EX bubbles, IF/ID squash on
// taken ID branches, and a saturating stall-cycle counter.
module hazard_bubble_unit #(
    parameter int                 CTRL_W   = pipeline_pkg::CTRL_W,
    parameter logic [CTRL_W-1:0]  NOP_CTRL = pipeline_pkg::NOP_CTRL,
    parameter int                 ADDR_W   = 5,
    parameter int                 MC_LAT   = 4,
    parameter int                 PERF_W   = 16
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic [CTRL_W-1:0] ctrl_i,
    input  logic [ADDR_W-1:0] ifid_rs_i,
    input  logic [ADDR_W-1:0] ifid_rt_i,
    input  logic              ifid_uses_rt_i,
    input  logic [1:0]        idex_memread_i,
    input  logic [ADDR_W-1:0] idex_rt_i,
    input  logic              idex_mc_i,
    input  logic              flush_i,
    output logic [CTRL_W-1:0] ctrl_o,
    output logic              pc_write_o,
    output logic              ifid_write_o,
    output logic              ifid_flush_o,
    output logic              stall_o,
    output logic              mc_busy_o,
    output logic [PERF_W-1:0] stall_cnt_o
);

    import pipeline_pkg::*;

    localparam int CNT_W = $clog2(MC_LAT) + 1;
    // The trigger cycle (still IDLE) is already one bubble, so MC_BUSY lasts MC_LAT-2
    // cycles; MC_LAT=2 needs only the trigger-cycle bubble and never leaves IDLE.
    localparam logic [CNT_W-1:0] CNT_LOAD = (MC_LAT > 2) ? CNT_W'(MC_LAT - 3) : '0;

    mc_state_e        state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             lu_haz;
    logic             mc_trig;
    logic             stall;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        lu_haz    = (idex_memread_i != 2'b00) && (idex_rt_i != '0) &&
                    ((idex_rt_i == ifid_rs_i) || (ifid_uses_rt_i && (idex_rt_i == ifid_rt_i)));
        mc_trig   = (state == IDLE) && idex_mc_i && (MC_LAT > 1);
        stall     = lu_haz || (state == MC_BUSY) || mc_trig;

        case (state)
            IDLE: begin
                if (idex_mc_i && (MC_LAT > 2)) begin
                    state_nxt = MC_BUSY;
                    cnt_nxt   = CNT_LOAD;
                end
            end
            MC_BUSY: begin
                if (cnt != '0) cnt_nxt = cnt - CNT_W'(1);
                else           state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs are forced to their quiescent values for as long as reset is held.
    always_comb begin
        ctrl_o       = NOP_CTRL;
        pc_write_o   = 1'b0;
        ifid_write_o = 1'b0;
        ifid_flush_o = 1'b0;
        stall_o      = 1'b0;
        mc_busy_o    = 1'b0;
        if (Rst_n) begin
            ctrl_o       = stall ? NOP_CTRL : ctrl_i;
            pc_write_o   = !stall;
            ifid_write_o = !stall;
            ifid_flush_o = flush_i && !stall;
            stall_o      = stall;
            mc_busy_o    = (state == MC_BUSY);
        end
    end

    sat_counter #(.W(PERF_W)) u_stall_cnt (
        .clk   (Clk),
        .rst_n (Rst_n),
        .en    (stall_o),
        .count (stall_cnt_o)
    );

endmodule

// File: tb/tb_hazard_bubble_unit.sv
// Directed bench for hazard_bubble_unit (MC_LAT=4, PERF_W=4) with hand-computed expectations.
module tb_hazard_bubble_unit;

    localparam int CTRL_W = 18;
    localparam int ADDR_W = 5;
    localparam int PERF_W = 4;

    logic              Clk;
    logic              Rst_n;
    logic [CTRL_W-1:0] ctrl_i;
    logic [ADDR_W-1:0] ifid_rs_i;
    logic [ADDR_W-1:0] ifid_rt_i;
    logic              ifid_uses_rt_i;
    logic [1:0]        idex_memread_i;
    logic [ADDR_W-1:0] idex_rt_i;
    logic              idex_mc_i;
    logic              flush_i;
    logic [CTRL_W-1:0] ctrl_o;
    logic              pc_write_o;
    logic              ifid_write_o;
    logic              ifid_flush_o;
    logic              stall_o;
    logic              mc_busy_o;
    logic [PERF_W-1:0] stall_cnt_o;

    int n_compared;
    int n_mismatched;
    logic [0:0] exp_q[$];

    hazard_bubble_unit #(
        .CTRL_W   (CTRL_W),
        .NOP_CTRL (18'h20000),
        .ADDR_W   (ADDR_W),
        .MC_LAT   (4),
        .PERF_W   (PERF_W)
    ) dut (
        .Clk            (Clk),
        .Rst_n          (Rst_n),
        .ctrl_i         (ctrl_i),
        .ifid_rs_i      (ifid_rs_i),
        .ifid_rt_i      (ifid_rt_i),
        .ifid_uses_rt_i (ifid_uses_rt_i),
        .idex_memread_i (idex_memread_i),
        .idex_rt_i      (idex_rt_i),
        .idex_mc_i      (idex_mc_i),
        .flush_i        (flush_i),
        .ctrl_o         (ctrl_o),
        .pc_write_o     (pc_write_o),
        .ifid_write_o   (ifid_write_o),
        .ifid_flush_o   (ifid_flush_o),
        .stall_o        (stall_o),
        .mc_busy_o      (mc_busy_o),
        .stall_cnt_o    (stall_cnt_o)
    );

    // clock / reset
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // drivers
    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic clear_hazards();
        ifid_rs_i      = '0;
        ifid_rt_i      = '0;
        ifid_uses_rt_i = 1'b0;
        idex_memread_i = 2'b00;
        idex_rt_i      = '0;
        idex_mc_i      = 1'b0;
        flush_i        = 1'b0;
    endtask

    task automatic pulse_reset();
        Rst_n = 1'b0;
        step();
        Rst_n = 1'b1;
        settle();
    endtask

    initial begin
        n_compared   = 0;
        n_mismatched = 0;
        Rst_n  = 1'b0;
        ctrl_i = 18'h3FFFF;
        clear_hazards();

        // reset state
        step();
        check("rst_ctrl", 32'(ctrl_o), 32'h20000);
        check("rst_pc_write", 32'(pc_write_o), 32'd0);
        check("rst_ifid_write", 32'(ifid_write_o), 32'd0);
        check("rst_stall_cnt", 32'(stall_cnt_o), 32'd0);
        check("rst_mc_busy", 32'(mc_busy_o), 32'd0);
        Rst_n = 1'b1;
        settle();
        check("rel_ctrl", 32'(ctrl_o), 32'h3FFFF);
        check("rel_pc_write", 32'(pc_write_o), 32'd1);
        check("rel_stall", 32'(stall_o), 32'd0);

        // load-use on rs
        idex_memread_i = 2'b01;
        idex_rt_i      = 5'd8;
        ifid_rs_i      = 5'd8;
        settle();
        check("lu_rs_stall", 32'(stall_o), 32'd1);
        check("lu_rs_ctrl", 32'(ctrl_o), 32'h20000);
        check("lu_rs_ifid_write", 32'(ifid_write_o), 32'd0);
        check("lu_rs_pc_write", 32'(pc_write_o), 32'd0);
        step();
        clear_hazards();
        settle();
        check("lu_rs_after_stall", 32'(stall_o), 32'd0);
        check("lu_rs_cnt", 32'(stall_cnt_o), 32'd1);

        // destination r0 is never a hazard
        idex_memread_i = 2'b10;
        idex_rt_i      = 5'd0;
        ifid_rs_i      = 5'd0;
        settle();
        check("lu_r0_stall", 32'(stall_o), 32'd0);

        // rt match only counts when rt is a source
        idex_rt_i      = 5'd9;
        ifid_rs_i      = 5'd3;
        ifid_rt_i      = 5'd9;
        ifid_uses_rt_i = 1'b0;
        settle();
        check("lu_rt_unused_stall", 32'(stall_o), 32'd0);
        check("lu_rt_unused_ctrl", 32'(ctrl_o), 32'h3FFFF);
        ifid_uses_rt_i = 1'b1;
        settle();
        check("lu_rt_used_stall", 32'(stall_o), 32'd1);
        idex_memread_i = 2'b00;
        settle();
        check("lu_no_load_stall", 32'(stall_o), 32'd0);
        idex_memread_i = 2'b11;
        settle();
        step();
        check("lu_rt_cnt", 32'(stall_cnt_o), 32'd2);

        // flush is suppressed while stalled, honoured once unstalled
        flush_i = 1'b1;
        settle();
        check("flush_stalled", 32'(ifid_flush_o), 32'd0);
        step();
        clear_hazards();
        flush_i = 1'b1;
        ctrl_i  = 18'h1A5C3;
        settle();
        check("flush_free", 32'(ifid_flush_o), 32'd1);
        check("flush_ctrl", 32'(ctrl_o), 32'h1A5C3);
        check("flush_cnt", 32'(stall_cnt_o), 32'd3);
        flush_i = 1'b0;

        // multi-cycle op: exactly 3 stall cycles, busy on cycles 2-3
        pulse_reset();
        exp_q.push_back(1'b1);
        exp_q.push_back(1'b1);
        exp_q.push_back(1'b1);
        exp_q.push_back(1'b0);
        idex_mc_i = 1'b1;
        settle();
        check("mc_c1_busy", 32'(mc_busy_o), 32'd0);
        check("mc_c1_stall", 32'(stall_o), 32'(exp_q.pop_front()));
        step();
        idex_mc_i = 1'b0;
        settle();
        check("mc_c2_busy", 32'(mc_busy_o), 32'd1);
        check("mc_c2_stall", 32'(stall_o), 32'(exp_q.pop_front()));
        check("mc_c2_ctrl", 32'(ctrl_o), 32'h20000);
        step();
        check("mc_c3_busy", 32'(mc_busy_o), 32'd1);
        check("mc_c3_stall", 32'(stall_o), 32'(exp_q.pop_front()));
        step();
        check("mc_c4_stall", 32'(stall_o), 32'(exp_q.pop_front()));
        check("mc_c4_busy", 32'(mc_busy_o), 32'd0);
        check("mc_c4_pc_write", 32'(pc_write_o), 32'd1);
        check("mc_c4_cnt", 32'(stall_cnt_o), 32'd3);

        // asynchronous reset during the second MC cycle
        idex_mc_i = 1'b1;
        step();
        idex_mc_i = 1'b0;
        settle();
        check("mr_busy_before", 32'(mc_busy_o), 32'd1);
        Rst_n = 1'b0;
        settle();
        check("mr_busy_async", 32'(mc_busy_o), 32'd0);
        check("mr_stall_async", 32'(stall_o), 32'd0);
        check("mr_cnt_async", 32'(stall_cnt_o), 32'd0);
        step();
        Rst_n = 1'b1;
        settle();
        check("mr_rel_stall", 32'(stall_o), 32'd0);
        check("mr_rel_busy", 32'(mc_busy_o), 32'd0);
        step();
        check("mr_next_stall", 32'(stall_o), 32'd0);
        check("mr_next_pc_write", 32'(pc_write_o), 32'd1);

        // saturation of the 4-bit stall counter
        pulse_reset();
        idex_memread_i = 2'b01;
        idex_rt_i      = 5'd17;
        ifid_rs_i      = 5'd17;
        for (int i = 0; i < 14; i++) step();
        check("sat_cnt_14", 32'(stall_cnt_o), 32'hE);
        for (int i = 0; i < 6; i++) step();
        check("sat_cnt_20", 32'(stall_cnt_o), 32'hF);
        check("sat_stall", 32'(stall_o), 32'd1);
        clear_hazards();
        settle();

        // final report
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
